// File: rtl/key_debouncer.sv
// key_debouncer: multi-channel key debouncer with prescaled stability counting and press/release pulses
module key_debouncer #(
  parameter int WIDTH = 18,
  parameter int DIV_LOG2 = 16,
  parameter int STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] INVERT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [WIDTH-1:0] s1, s2;
  logic [CW-1:0] cnt [WIDTH];
  logic tick;
  generate
    if (DIV_LOG2 == 0) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_LOG2-1:0] pre;
      always_ff @(posedge clk) pre <= rst ? '0 : pre + 1'b1;
      assign tick = &pre;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      key_out <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1 <= key_in ^ INVERT;
      s2 <= s1;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == key_out[i]) cnt[i] <= '0;
        else if (tick && cnt[i] == LAST) begin
          key_out[i] <= s2[i];
          cnt[i] <= '0;
          rise[i] <= s2[i];
          fall[i] <= ~s2[i];
        end else if (tick) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  assign any_change = |(rise | fall);
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: randomized and directed checks of key_debouncer against a tick-arithmetic model
module tb_key_debouncer;
  localparam int W = 4, DL = 2, P = 4, ST = 3;
  localparam logic [3:0] INV = 4'b1000;
  logic clk = 0, rst = 1;
  logic [3:0] key_in = INV, key_out, rise, fall;
  logic any_change;
  int checks = 0, failures = 0;

  key_debouncer #(.WIDTH(W), .DIV_LOG2(DL), .STABLE_TICKS(ST), .INVERT(INV)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .rise(rise), .fall(fall), .any_change(any_change));

  always #5 clk = ~clk;

  // Model: a disagreement run starting at edge r completes at the ST-th tick edge (multiple of P) in [r, e]
  int e = 0;
  int r [4];
  bit run [4];
  logic [3:0] m_s1 = 0, m_s2 = 0, m_out = 0, m_rise = 0, m_fall = 0;
  always @(posedge clk) begin
    if (rst) begin
      e = 0; m_s1 = 0; m_s2 = 0; m_out = 0; m_rise = 0; m_fall = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      e++;
      m_rise = 0;
      m_fall = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_out[i]) begin
          if (!run[i]) begin run[i] = 1; r[i] = e; end
          if (e % P == 0 && e / P - (r[i] - 1) / P == ST) begin
            m_out[i] = m_s2[i];
            m_rise[i] = m_s2[i];
            m_fall[i] = !m_s2[i];
            run[i] = 0;
          end
        end else run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = key_in ^ INV;
    end
  end

  task automatic do_reset(input logic [3:0] k);
    @(negedge clk);
    rst = 1;
    key_in = k;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset(4'b1000);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checks++;
      if ({key_out, rise, fall, any_change} !== 13'b0) begin
        failures++;
        $display("FAIL idle edge %0d: out=%b rise=%b fall=%b any=%b, required all 0", k, key_out, rise, fall, any_change);
      end
    end
  endtask

  task automatic test_press;
    do_reset(4'b1001);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (key_out !== (k >= 12 ? 4'b0001 : 4'b0000) || rise !== (k == 12 ? 4'b0001 : 4'b0000) || fall !== 4'b0) begin
        failures++;
        $display("FAIL press edge %0d: out=%b rise=%b fall=%b, required out=%b rise=%b fall=0000", k, key_out, rise, fall,
                 k >= 12 ? 4'b0001 : 4'b0000, k == 12 ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_bounce;
    int pulses = 0;
    for (int k = 0; k < 60; k++) begin
      key_in[1] = (k < 12) ? ((k / 3) % 2 == 0) : 1'b1;
      @(negedge clk);
      pulses += rise[1];
      checks++;
      if ({key_out, rise, fall, any_change} !== {m_out, m_rise, m_fall, |(m_rise | m_fall)}) begin
        failures++;
        $display("FAIL bounce cycle %0d: out=%b rise=%b fall=%b, model out=%b rise=%b fall=%b", k, key_out, rise, fall, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (pulses != 1 || key_out[1] !== 1'b1) begin
      failures++;
      $display("FAIL bounce pulses: got %0d pulses out1=%b, required 1 pulse out1=1", pulses, key_out[1]);
    end
  endtask

  task automatic test_polarity;
    int rises = 0, falls = 0;
    do_reset(4'b1000);
    for (int k = 0; k < 40; k++) begin
      if (k == 20) key_in[3] = 1'b1;
      else if (k == 0) key_in[3] = 1'b0;
      @(negedge clk);
      rises += rise[3];
      falls += fall[3];
      checks++;
      if ({key_out, rise, fall, any_change} !== {m_out, m_rise, m_fall, |(m_rise | m_fall)}) begin
        failures++;
        $display("FAIL polarity cycle %0d: out=%b rise=%b fall=%b, model out=%b rise=%b fall=%b", k, key_out, rise, fall, m_out, m_rise, m_fall);
      end
      if (k == 19) begin
        checks++;
        if (key_out[3] !== 1'b1 || rises != 1) begin
          failures++;
          $display("FAIL polarity press: out3=%b rises=%0d, required out3=1 rises=1", key_out[3], rises);
        end
      end
    end
    checks++;
    if (key_out[3] !== 1'b0 || falls != 1) begin
      failures++;
      $display("FAIL polarity release: out3=%b falls=%0d, required out3=0 falls=1", key_out[3], falls);
    end
  endtask

  task automatic test_simultaneous;
    int hits = 0;
    key_in = key_in | 4'b0101;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (any_change) begin
        hits++;
        checks++;
        if (rise !== 4'b0101 || fall !== 4'b0) begin
          failures++;
          $display("FAIL simultaneous pulse: rise=%b fall=%b, required rise=0101 fall=0000", rise, fall);
        end
      end
    end
    checks++;
    if (hits != 1) begin
      failures++;
      $display("FAIL simultaneous count: any_change cycles=%0d, required 1", hits);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(4'b1001);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({key_out, rise, fall, any_change} !== 13'b0) begin
      failures++;
      $display("FAIL midreset outputs: out=%b rise=%b fall=%b any=%b, required all 0", key_out, rise, fall, any_change);
    end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (rise !== (k == 12 ? 4'b0001 : 4'b0000) || key_out !== (k >= 12 ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL midreset edge %0d: out=%b rise=%b, required rise=%b", k, key_out, rise, k == 12 ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random;
    int hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        key_in[$urandom_range(3, 0)] ^= 1'b1;
        hold = $urandom_range(30, 1);
      end
      hold--;
      if ($urandom_range(399, 0) == 0) rst = 1;
      @(negedge clk);
      rst = 0;
      checks++;
      if ({key_out, rise, fall, any_change} !== {m_out, m_rise, m_fall, |(m_rise | m_fall)}) begin
        failures++;
        $display("FAIL random cycle %0d: out=%b rise=%b fall=%b any=%b, model out=%b rise=%b fall=%b", k, key_out, rise, fall, any_change, m_out, m_rise, m_fall);
      end
    end
  endtask

  initial begin
    test_reset;
    test_press;
    test_bounce;
    test_polarity;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_debouncer.md
# key_debouncer

Parametrised multi-channel key debouncer with edge detection. It replaces the free-running divider-plus-resample scheme for the push-buttons and switches on the board. Each channel is synchronised, polarity-normalised and accepted only after it has held steady for a programmable number of prescaler ticks. The block emits clean levels plus one-cycle press/release pulses to the crypto control logic.

## Interface
- `WIDTH`, 18: number of independent key channels.
- `DIV_LOG2`, 16: prescaler width; tick period P = 2^DIV_LOG2 clocks; 0 means a tick every cycle; legal range 0..24.
- `STABLE_TICKS`, 4: consecutive ticks of disagreement required to accept a new level; legal range ≥ 1.
- `INVERT`, {WIDTH{1'b0}}: per-bit mask; a set bit marks an active-low key, which is XORed before synchronisation.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `key_in` input, WIDTH bits: raw asynchronous key/switch levels.
- `key_out` output, WIDTH bits: debounced logical level; 1 = pressed/on.
- `rise` output, WIDTH bits: one-cycle pulse when `key_out[i]` goes 0→1.
- `fall` output, WIDTH bits: one-cycle pulse when `key_out[i]` goes 1→0.
- `any_change` output, 1 bit: OR-reduction of `rise | fall`.

## Operation
- Normalise: `n = key_in ^ INVERT`.
- Synchronise: a 2-flop chain per bit, `s1 <= n` then `s2 <= s1`. Only `s2` feeds the logic.
- Prescaler:
  - DIV_LOG2-bit free-running counter, wraps at P−1 → 0.
  - `tick` is combinational and high while the counter equals P−1.
  - When DIV_LOG2 = 0, `tick` is constant 1.
- Per-channel stability counter `cnt[i]`, width clog2(STABLE_TICKS+1). On each clock edge:
  - If `s2[i] == key_out[i]`: `cnt[i] <= 0`. Bounce or agreement restarts the count, regardless of `tick`.
  - Else if `tick` and `cnt[i] == STABLE_TICKS−1`: `key_out[i] <= s2[i]`, `cnt[i] <= 0`, and set `rise[i]` or `fall[i]` according to the new level.
  - Else if `tick`: `cnt[i] <= cnt[i] + 1`.
  - Else: hold.
- `rise`/`fall` are registered and cleared every cycle unless set by the rule above. A pulse lasts exactly one cycle. `rise[i]` and `fall[i]` are never high together.
- Channels are fully independent. Any mix of channels may flip on the same edge, and each produces its own pulse.
- `any_change` is combinational from the registered `rise`/`fall`.

## Timing
- Reset (synchronous, edge with `rst` = 1) clears `s1`, `s2`, prescaler, all `cnt`, `key_out`, `rise`, `fall` to 0. Therefore `any_change` = 0.
- Reset mid-count discards progress. A key still held after reset is re-debounced from scratch and produces a `rise`.
- Edge numbering: edge 1 is the first edge with `rst` = 0. The prescaler value after edge k is k mod P. Tick is sampled at edges P, 2P, 3P, …
- Latency:
  - Input stable from before edge 1 → mismatch visible after edge 2.
  - `key_out` flips at the STABLE_TICKS-th tick-sampling edge after that.
  - General bound: from 2 + (STABLE_TICKS−1)·P + 1 to 2 + STABLE_TICKS·P clocks.
- Pulses align with the `key_out` change: both are visible after the same edge.
- Prescaler wrap P−1 → 0 has no side effect beyond the tick.
- A glitch shorter than 2 cycles may still reach `s2`. It resets nothing, because a mismatch lasting less than one tick never completes a count.

## Test plan
- Reset and idle (DIV_LOG2 = 2, STABLE_TICKS = 3, WIDTH = 4, INVERT = 0): hold `key_in` = 0 for 50 cycles → `key_out` = 0, `rise` = `fall` = 0, `any_change` = 0 throughout.
- Clean press: `key_in` = 4'b0001 from before edge 1 → `cnt[0]` = 1 after edge 4, 2 after edge 8. `key_out` = 4'b0001 and `rise` = 4'b0001 after edge 12. `rise` returns to 0 after edge 13. `fall` stays 0.
- Bounce: toggle `key_in[1]` 1,0,1,0 every 3 cycles, then hold 1 → no `key_out[1]` change until 3 consecutive ticks see `s2[1]` = 1, then exactly one `rise[1]` pulse.
- Release and polarity (INVERT = 4'b1000): reset with `key_in[3]` = 1 → `key_out[3]` stays 0. Drive `key_in[3]` = 0 → `rise[3]` after the 3rd tick. Drive `key_in[3]` = 1 → `fall[3]` after another 3 ticks.
- Simultaneous channels: press keys 0 and 2 on the same cycle → `rise` = 4'b0101 on a single cycle, with `any_change` = 1 for that cycle only.
- Reset mid-count: hold `key_in[0]` = 1 and assert `rst` for 1 cycle after edge 9 (cnt = 2) → all outputs 0. The count restarts, and `rise[0]` appears 12 edges after reset release.
